// File: rtl/sp_bank_driver_pkg.sv
// Shared types for the scratchpad bank driver: command opcodes, read-request
// types, FSM states and the packed layouts of the two bank request FIFOs.
package sp_bank_driver_pkg;

    localparam int DEF_BITS_PER_ROW = 64;
    localparam int DEF_MAT_S_W      = 3;
    localparam int DEF_ROW_S_W      = 2;
    localparam int DEF_WORD_W       = 32;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_FETCH = 2'b10,
        OP_NOP   = 2'b11
    } sp_op_t;

    typedef enum logic [1:0] {
        RREQ_DRAM = 2'b00,
        RREQ_GEMM = 2'b01
    } rreq_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RDREQ,
        ST_DONE
    } drv_state_t;

    // Write-FIFO entry: {pad, matrix, row, row data}
    typedef struct packed {
        logic                        pad;
        logic [DEF_MAT_S_W-1:0]      mat;
        logic [DEF_ROW_S_W-1:0]      row;
        logic [DEF_BITS_PER_ROW-1:0] data;
    } wfifo_pkt_t;

    // Read-request FIFO entry: {type, matrix, row, DRAM address}
    typedef struct packed {
        rreq_type_t                  rtype;
        logic [DEF_MAT_S_W-1:0]      mat;
        logic [DEF_ROW_S_W-1:0]      row;
        logic [DEF_WORD_W-1:0]       addr;
    } rfifo_pkt_t;

endpackage

// File: rtl/sp_bank_driver_resp_slot.sv
// One-entry valid/ready output register fed from a first-word-fall-through
// FIFO. A new entry is popped whenever the slot is empty or being drained in
// the same cycle, so a continuously ready consumer sees full throughput.
module sp_resp_slot
    import sp_bank_driver_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         fifoEmpty,
    input  logic [W-1:0] fifoData,
    output logic         fifoRen,
    output logic         outValid,
    output logic [W-1:0] outPkt,
    input  logic         outReady
);

    assign fifoRen = !fifoEmpty && (!outValid || outReady);

    // Load the slot on a pop, otherwise release it once the consumer takes it
    always_ff @(posedge clk) begin
        if (!nRst) begin
            outValid <= 1'b0;
            outPkt   <= '0;
        end else if (fifoRen) begin
            outValid <= 1'b1;
            outPkt   <= fifoData;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: rtl/sp_bank_driver.sv
// Requester-side engine for one scratchpad bank. Expands whole-matrix LOAD,
// STORE and FETCH commands into per-row FIFO pushes and drains the bank's
// DRAM and GEMM response FIFOs into registered valid/ready outputs.
module sp_bank_driver
    import sp_bank_driver_pkg::*;
#(
    parameter int BITS_PER_ROW = DEF_BITS_PER_ROW,
    parameter int MAT_S_W      = DEF_MAT_S_W,
    parameter int ROW_S_W      = DEF_ROW_S_W,
    parameter int WORD_W       = DEF_WORD_W
) (
    input  logic                                        CLK,
    input  logic                                        nRST,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [1:0]                                  cmd_op,
    input  logic [MAT_S_W-1:0]                          cmd_mat,
    input  logic [WORD_W-1:0]                           cmd_addr,
    input  logic                                        ld_valid,
    output logic                                        ld_ready,
    input  logic [BITS_PER_ROW-1:0]                     ld_data,
    output logic                                        done,
    output logic                                        wFIFO_WEN,
    output logic [BITS_PER_ROW+MAT_S_W+ROW_S_W:0]       wFIFO_wdata,
    input  logic                                        wFIFO_full,
    output logic                                        rFIFO_WEN,
    output logic [WORD_W+MAT_S_W+ROW_S_W+1:0]           rFIFO_wdata,
    input  logic                                        rFIFO_full,
    output logic                                        dramFIFO_REN,
    input  logic                                        dramFIFO_empty,
    input  logic [WORD_W+BITS_PER_ROW+MAT_S_W+ROW_S_W-1:0] dramFIFO_rdata,
    output logic                                        gemmFIFO_REN,
    input  logic                                        gemmFIFO_empty,
    input  logic [BITS_PER_ROW+MAT_S_W+ROW_S_W+1:0]     gemmFIFO_rdata,
    input  logic                                        gemm_complete,
    output logic                                        st_valid,
    output logic [WORD_W+BITS_PER_ROW+MAT_S_W+ROW_S_W-1:0] st_pkt,
    input  logic                                        st_ready,
    output logic                                        gm_valid,
    output logic [BITS_PER_ROW+MAT_S_W+ROW_S_W+1:0]     gm_pkt,
    input  logic                                        gm_ready,
    output logic                                        gemm_done
);

    localparam int ROWS      = 1 << ROW_S_W;
    localparam int ROW_BYTES = BITS_PER_ROW / 8;
    localparam int DRAM_W    = WORD_W + BITS_PER_ROW + MAT_S_W + ROW_S_W;
    localparam int GEMM_W    = BITS_PER_ROW + MAT_S_W + ROW_S_W + 2;

    drv_state_t          state;
    sp_op_t              curOp;
    logic [MAT_S_W-1:0]  curMat;
    logic [WORD_W-1:0]   baseAddr;
    logic [ROW_S_W-1:0]  row;
    logic                cmdReadyReg;
    logic                doneReg;
    logic                gemmDoneReg;

    logic                lastRow;
    logic                loadPush;
    logic                reqPush;
    logic [1:0]          reqType;
    logic [WORD_W-1:0]   reqAddr;

    assign lastRow  = (row == ROW_S_W'(ROWS - 1));
    assign loadPush = (state == ST_LOAD) && ld_valid && !wFIFO_full;
    assign reqPush  = (state == ST_RDREQ) && !rFIFO_full;
    assign reqType  = (curOp == OP_FETCH) ? RREQ_GEMM : RREQ_DRAM;
    assign reqAddr  = baseAddr + WORD_W'(row) * WORD_W'(ROW_BYTES);

    assign ld_ready    = (state == ST_LOAD) && !wFIFO_full;
    assign wFIFO_WEN   = loadPush;
    assign wFIFO_wdata = {1'b0, curMat, row, ld_data};
    assign rFIFO_WEN   = reqPush;
    assign rFIFO_wdata = {reqType, curMat, row, reqAddr};
    assign cmd_ready   = cmdReadyReg;
    assign done        = doneReg;
    assign gemm_done   = gemmDoneReg;

    // Command FSM: latch a command, step one row per accepted push, pulse done
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= ST_IDLE;
            curOp       <= OP_NOP;
            curMat      <= '0;
            baseAddr    <= '0;
            row         <= '0;
            cmdReadyReg <= 1'b1;
            doneReg     <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmdReadyReg) begin
                        curOp       <= sp_op_t'(cmd_op);
                        curMat      <= cmd_mat;
                        baseAddr    <= cmd_addr;
                        row         <= '0;
                        cmdReadyReg <= 1'b0;
                        case (sp_op_t'(cmd_op))
                            OP_LOAD: state <= ST_LOAD;
                            OP_NOP:  state <= ST_DONE;
                            default: state <= ST_RDREQ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (loadPush) begin
                        row <= row + ROW_S_W'(1);
                        if (lastRow) state <= ST_DONE;
                    end
                end
                ST_RDREQ: begin
                    if (reqPush) begin
                        row <= row + ROW_S_W'(1);
                        if (lastRow) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    doneReg     <= 1'b1;
                    cmdReadyReg <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    cmdReadyReg <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered copy of the bank's GEMM completion flag
    always_ff @(posedge CLK) begin
        if (!nRST) gemmDoneReg <= 1'b0;
        else       gemmDoneReg <= gemm_complete;
    end

    sp_resp_slot #(.W(DRAM_W)) dramSlot (
        .clk      (CLK),
        .nRst     (nRST),
        .fifoEmpty(dramFIFO_empty),
        .fifoData (dramFIFO_rdata),
        .fifoRen  (dramFIFO_REN),
        .outValid (st_valid),
        .outPkt   (st_pkt),
        .outReady (st_ready)
    );

    sp_resp_slot #(.W(GEMM_W)) gemmSlot (
        .clk      (CLK),
        .nRst     (nRST),
        .fifoEmpty(gemmFIFO_empty),
        .fifoData (gemmFIFO_rdata),
        .fifoRen  (gemmFIFO_REN),
        .outValid (gm_valid),
        .outPkt   (gm_pkt),
        .outReady (gm_ready)
    );

endmodule

// File: tb/tb_sp_bank_driver.sv
// Self-checking bench for sp_bank_driver: randomized commands and FIFO
// traffic checked against expectations computed from row/address arithmetic.
module tb_sp_bank_driver;
    import sp_bank_driver_pkg::*;

    localparam int ROWS = 4;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [2:0]   cmd_mat;
    logic [31:0]  cmd_addr;
    logic         ld_valid, ld_ready;
    logic [63:0]  ld_data;
    logic         done;
    logic         wFIFO_WEN, wFIFO_full;
    logic [69:0]  wFIFO_wdata;
    logic         rFIFO_WEN, rFIFO_full;
    logic [38:0]  rFIFO_wdata;
    logic         dramFIFO_REN, dramFIFO_empty;
    logic [100:0] dramFIFO_rdata;
    logic         gemmFIFO_REN, gemmFIFO_empty;
    logic [70:0]  gemmFIFO_rdata;
    logic         gemm_complete, gemm_done;
    logic         st_valid, st_ready;
    logic [100:0] st_pkt;
    logic         gm_valid, gm_ready;
    logic [70:0]  gm_pkt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int illegal = 0;

    logic [69:0] wLog[$];
    int          wCyc[$];
    logic [38:0] rLog[$];
    int          rCyc[$];
    int          doneCyc[$];

    sp_bank_driver dut (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mat(cmd_mat), .cmd_addr(cmd_addr),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .done(done),
        .wFIFO_WEN(wFIFO_WEN), .wFIFO_wdata(wFIFO_wdata), .wFIFO_full(wFIFO_full),
        .rFIFO_WEN(rFIFO_WEN), .rFIFO_wdata(rFIFO_wdata), .rFIFO_full(rFIFO_full),
        .dramFIFO_REN(dramFIFO_REN), .dramFIFO_empty(dramFIFO_empty),
        .dramFIFO_rdata(dramFIFO_rdata),
        .gemmFIFO_REN(gemmFIFO_REN), .gemmFIFO_empty(gemmFIFO_empty),
        .gemmFIFO_rdata(gemmFIFO_rdata),
        .gemm_complete(gemm_complete),
        .st_valid(st_valid), .st_pkt(st_pkt), .st_ready(st_ready),
        .gm_valid(gm_valid), .gm_pkt(gm_pkt), .gm_ready(gm_ready),
        .gemm_done(gemm_done)
    );

    always #5 CLK = ~CLK;

    // Edge counter used to time pushes and done pulses
    always @(posedge CLK) cyc <= cyc + 1;

    // Log every push (it lands on the next edge), every done pulse, and any
    // push/pop against a full/empty FIFO
    always @(negedge CLK) begin
        if (wFIFO_WEN) begin wLog.push_back(wFIFO_wdata); wCyc.push_back(cyc + 1); end
        if (rFIFO_WEN) begin rLog.push_back(rFIFO_wdata); rCyc.push_back(cyc + 1); end
        if (done) doneCyc.push_back(cyc);
        if ((wFIFO_WEN && wFIFO_full) || (rFIFO_WEN && rFIFO_full) ||
            (dramFIFO_REN && dramFIFO_empty) || (gemmFIFO_REN && gemmFIFO_empty))
            illegal++;
    end

    task automatic clearLogs();
        wLog.delete(); wCyc.delete(); rLog.delete(); rCyc.delete(); doneCyc.delete();
    endtask

    task automatic issueCmd(input logic [1:0] op, input logic [2:0] mat,
                            input logic [31:0] addr, output int acc);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_mat = mat; cmd_addr = addr;
        @(negedge CLK);
        while (!cmd_ready && n < 20) begin @(negedge CLK); n++; end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge CLK); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; gemm_complete = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        @(negedge CLK);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b required 0", done); end
        tests++; if (st_valid !== 1'b0 || gm_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: st=%b gm=%b required 0 0", st_valid, gm_valid); end
        tests++; if (gemm_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_gemm_done: got %b required 0", gemm_done); end
        tests++; if (ld_ready !== 1'b0 || wFIFO_WEN !== 1'b0 || rFIFO_WEN !== 1'b0) begin fails++; $display("[TB] FAIL reset_push: ld_ready=%b wen=%b ren=%b required 0 0 0", ld_ready, wFIFO_WEN, rFIFO_WEN); end
        @(posedge CLK); #1;
        nRST = 1'b1; gemm_complete = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_load(input bit stalls);
        logic [63:0] beats[4];
        logic [2:0]  m;
        wfifo_pkt_t  e;
        int acc, n, gaps;
        m = stalls ? 3'($urandom) : 3'd5;
        for (int i = 0; i < 4; i++) beats[i] = stalls ? {$urandom, $urandom} : 64'(10 + i);
        clearLogs();
        issueCmd(2'b00, m, $urandom, acc);
        for (int i = 0; i < 4; i++) begin
            if (stalls) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin ld_valid = 1'b0; @(posedge CLK); #1; end
            end
            ld_valid = 1'b1; ld_data = beats[i];
            wFIFO_full = stalls && ($urandom_range(0, 2) == 0);
            n = 0;
            @(negedge CLK);
            while (!ld_ready && n < 20) begin
                @(posedge CLK); #1;
                wFIFO_full = stalls && ($urandom_range(0, 2) == 0);
                @(negedge CLK); n++;
            end
            if (!ld_ready) begin tests++; fails++; $display("[TB] FAIL load_wait: ld_ready=%b required 1", ld_ready); end
            @(posedge CLK); #1;
        end
        ld_valid = 1'b0; wFIFO_full = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        tests++;
        if (wLog.size() != 4) begin fails++; $display("[TB] FAIL load_count: got %0d pushes required 4", wLog.size()); end
        for (int i = 0; i < 4 && i < wLog.size(); i++) begin
            e.pad = 1'b0; e.mat = m; e.row = 2'(i); e.data = beats[i];
            tests++;
            if (wLog[i] !== e) begin fails++; $display("[TB] FAIL load_row%0d: got %h required %h", i, wLog[i], e); end
            if (!stalls) begin
                tests++;
                if (wCyc[i] != acc + 1 + i) begin fails++; $display("[TB] FAIL load_push_cycle%0d: got %0d required %0d", i, wCyc[i] - acc, i + 1); end
            end
        end
        tests++;
        if (doneCyc.size() != 1) begin
            fails++; $display("[TB] FAIL load_done_count: got %0d required 1", doneCyc.size());
        end else if (!stalls) begin
            tests++;
            if (doneCyc[0] - acc + 1 != ROWS + 2) begin fails++; $display("[TB] FAIL load_done_latency: got %0d required %0d", doneCyc[0] - acc + 1, ROWS + 2); end
        end else if (wCyc.size() == 4) begin
            tests++;
            if (doneCyc[0] != wCyc[3] + 1) begin fails++; $display("[TB] FAIL load_done_after_last: got %0d required %0d", doneCyc[0], wCyc[3] + 1); end
        end
    endtask

    // mode 0: no backpressure, 1: rFIFO full for cycles 3..5, 2: random full
    task automatic test_rreq(input logic [1:0] op, input logic [2:0] mat,
                             input logic [31:0] addr, input int mode);
        int         acc;
        int         stallRel[4];
        logic [1:0] expT;
        rfifo_pkt_t r;
        logic [31:0] ea;
        stallRel = '{1, 2, 6, 7};
        expT = (op == 2'b10) ? 2'b01 : 2'b00;
        clearLogs();
        issueCmd(op, mat, addr, acc);
        for (int j = 1; j <= 30; j++) begin
            if (mode == 1)      rFIFO_full = (j >= 3 && j <= 5);
            else if (mode == 2) rFIFO_full = ($urandom_range(0, 2) == 0);
            else                rFIFO_full = 1'b0;
            @(posedge CLK); #1;
        end
        rFIFO_full = 1'b0;
        tests++;
        if (rLog.size() != 4) begin fails++; $display("[TB] FAIL rreq_count: got %0d required 4", rLog.size()); end
        for (int i = 0; i < 4 && i < rLog.size(); i++) begin
            r = rLog[i];
            ea = addr + 32'(i * 8);
            tests++;
            if (r.addr !== ea || r.row !== 2'(i) || r.mat !== mat || r.rtype !== expT) begin
                fails++;
                $display("[TB] FAIL rreq_row%0d: got type=%0d mat=%0d row=%0d addr=%h required type=%0d mat=%0d row=%0d addr=%h",
                         i, r.rtype, r.mat, r.row, r.addr, expT, mat, i, ea);
            end
            if (mode != 2) begin
                tests++;
                if (rCyc[i] - acc != ((mode == 1) ? stallRel[i] : i + 1)) begin
                    fails++; $display("[TB] FAIL rreq_cycle%0d: got %0d required %0d", i, rCyc[i] - acc, (mode == 1) ? stallRel[i] : i + 1);
                end
            end
        end
        tests++;
        if (doneCyc.size() != 1) begin
            fails++; $display("[TB] FAIL rreq_done_count: got %0d required 1", doneCyc.size());
        end else if (mode != 2) begin
            tests++;
            if (doneCyc[0] - acc + 1 != ROWS + 2 + ((mode == 1) ? 3 : 0)) begin
                fails++; $display("[TB] FAIL rreq_done_latency: got %0d required %0d", doneCyc[0] - acc + 1, ROWS + 2 + ((mode == 1) ? 3 : 0));
            end
        end else if (rCyc.size() == 4) begin
            tests++;
            if (doneCyc[0] != rCyc[3] + 1) begin fails++; $display("[TB] FAIL rreq_done_after_last: got %0d required %0d", doneCyc[0], rCyc[3] + 1); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] table_[4];
        rfifo_pkt_t  r;
        table_ = '{32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008, 32'h0000_0010};
        test_rreq(2'b01, 3'($urandom), 32'hFFFF_FFF8, 0);
        for (int i = 0; i < 4 && i < rLog.size(); i++) begin
            r = rLog[i];
            tests++;
            if (r.addr !== table_[i]) begin fails++; $display("[TB] FAIL wrap_addr%0d: got %h required %h", i, r.addr, table_[i]); end
        end
    endtask

    task automatic test_nop();
        int acc;
        clearLogs();
        issueCmd(2'b11, 3'd0, 32'd0, acc);
        repeat (5) begin @(posedge CLK); #1; end
        tests++;
        if (wLog.size() != 0 || rLog.size() != 0) begin fails++; $display("[TB] FAIL nop_pushes: got %0d/%0d required 0/0", wLog.size(), rLog.size()); end
        tests++;
        if (doneCyc.size() != 1) begin fails++; $display("[TB] FAIL nop_done_count: got %0d required 1", doneCyc.size()); end
    endtask

    task automatic test_drain();
        logic [100:0] dq[$], dExp[$], dGot[$];
        logic [70:0]  gq[$], gExp[$], gGot[$];
        logic [100:0] dItem;
        logic [70:0]  gItem;
        int  badPop;
        bit  popD, popG;
        badPop = 0;
        for (int i = 0; i < 3; i++) begin dItem = 101'({$urandom, $urandom, $urandom, $urandom}); dq.push_back(dItem); dExp.push_back(dItem); end
        for (int i = 0; i < 4; i++) begin gItem = 71'({$urandom, $urandom, $urandom}); gq.push_back(gItem); gExp.push_back(gItem); end
        for (int j = 1; j <= 25; j++) begin
            st_ready = (j > 2);
            gm_ready = (j > 20) ? 1'b1 : 1'($urandom_range(0, 1));
            dramFIFO_empty = (dq.size() == 0);
            dramFIFO_rdata = (dq.size() == 0) ? '0 : dq[0];
            gemmFIFO_empty = (gq.size() == 0);
            gemmFIFO_rdata = (gq.size() == 0) ? '0 : gq[0];
            @(negedge CLK);
            if ((st_valid && !st_ready && dramFIFO_REN) || (gm_valid && !gm_ready && gemmFIFO_REN)) badPop++;
            popD = dramFIFO_REN; popG = gemmFIFO_REN;
            if (st_valid && st_ready) dGot.push_back(st_pkt);
            if (gm_valid && gm_ready) gGot.push_back(gm_pkt);
            @(posedge CLK); #1;
            if (popD && dq.size() > 0) void'(dq.pop_front());
            if (popG && gq.size() > 0) void'(gq.pop_front());
        end
        dramFIFO_empty = 1'b1; gemmFIFO_empty = 1'b1; st_ready = 1'b0; gm_ready = 1'b0;
        tests++;
        if (badPop != 0) begin fails++; $display("[TB] FAIL drain_pop_while_held: got %0d pops required 0", badPop); end
        tests++;
        if (dGot.size() != 3) begin fails++; $display("[TB] FAIL drain_st_count: got %0d required 3", dGot.size()); end
        for (int i = 0; i < 3 && i < dGot.size(); i++) begin
            tests++;
            if (dGot[i] !== dExp[i]) begin fails++; $display("[TB] FAIL drain_st%0d: got %h required %h", i, dGot[i], dExp[i]); end
        end
        tests++;
        if (gGot.size() != 4) begin fails++; $display("[TB] FAIL drain_gm_count: got %0d required 4", gGot.size()); end
        for (int i = 0; i < 4 && i < gGot.size(); i++) begin
            tests++;
            if (gGot[i] !== gExp[i]) begin fails++; $display("[TB] FAIL drain_gm%0d: got %h required %h", i, gGot[i], gExp[i]); end
        end
    endtask

    task automatic test_gemm_done();
        logic v;
        for (int j = 0; j < 8; j++) begin
            v = 1'($urandom_range(0, 1));
            gemm_complete = v;
            @(posedge CLK); #1;
            tests++;
            if (gemm_done !== v) begin fails++; $display("[TB] FAIL gemm_done%0d: got %b required %b", j, gemm_done, v); end
        end
        gemm_complete = 1'b0;
    endtask

    task automatic test_midreset();
        int acc;
        clearLogs();
        issueCmd(2'b00, 3'd1, 32'd0, acc);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = {$urandom, $urandom};
            @(posedge CLK); #1;
        end
        ld_valid = 1'b0;
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        tests++;
        if (cmd_ready !== 1'b1 || ld_ready !== 1'b0) begin fails++; $display("[TB] FAIL midreset_idle: cmd_ready=%b ld_ready=%b required 1 0", cmd_ready, ld_ready); end
        repeat (6) begin @(posedge CLK); #1; end
        tests++;
        if (doneCyc.size() != 0) begin fails++; $display("[TB] FAIL midreset_no_done: got %0d pulses required 0", doneCyc.size()); end
        tests++;
        if (wLog.size() != 2) begin fails++; $display("[TB] FAIL midreset_pushes: got %0d required 2", wLog.size()); end
        test_rreq(2'b10, 3'($urandom), $urandom, 0);
    endtask

    initial begin
        nRST = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_mat = '0; cmd_addr = '0;
        ld_valid = 1'b0; ld_data = '0; wFIFO_full = 1'b0; rFIFO_full = 1'b0;
        dramFIFO_empty = 1'b1; dramFIFO_rdata = '0; gemmFIFO_empty = 1'b1; gemmFIFO_rdata = '0;
        gemm_complete = 1'b0; st_ready = 1'b0; gm_ready = 1'b0;

        test_reset();
        test_load(1'b0);
        test_load(1'b1);
        test_rreq(2'b01, 3'd2, 32'h0000_1000, 0);
        test_rreq(2'b10, 3'd2, 32'h0000_1000, 0);
        test_rreq(2'b01, 3'd2, 32'h0000_1000, 1);
        for (int k = 0; k < 3; k++) test_rreq(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 3'($urandom), $urandom, 2);
        test_wrap();
        test_nop();
        test_drain();
        test_gemm_done();
        test_midreset();

        tests++;
        if (illegal != 0) begin fails++; $display("[TB] FAIL fifo_protocol: got %0d illegal push/pop cycles required 0", illegal); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sp_bank_driver.md
Name: sp_bank_driver

Overview:
Requester-side engine for one scratchpad bank; drives the bank's FIFO ports (wFIFO_WEN/wdata, rFIFO_WEN/wdata, dramFIFO_REN, gemmFIFO_REN) and consumes its status and read-data outputs. Turns whole-matrix commands into per-row FIFO pushes:
- LOAD: DRAM row stream into the bank.
- STORE: row readout toward DRAM.
- FETCH: row readout toward GEMM.

It also drains the bank's DRAM and GEMM response FIFOs into registered valid/ready outputs.

Parameters:
- BITS_PER_ROW, 64, bits per matrix row.
- MAT_S_W, 3, matrix-select width.
- ROW_S_W, 2, row-select width; ROWS = 2^ROW_S_W.
- WORD_W, 32, DRAM address width.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  driver in IDLE
- cmd_op  in  2  00 LOAD, 01 STORE, 10 FETCH, 11 NOP
- cmd_mat  in  MAT_S_W  target matrix
- cmd_addr  in  WORD_W  DRAM base address (STORE/FETCH)
- ld_valid  in  1  LOAD row beat valid
- ld_ready  out  1  LOAD row beat accepted
- ld_data  in  BITS_PER_ROW  LOAD row data
- done  out  1  one-cycle pulse, command finished
- wFIFO_WEN  out  1  bank write-FIFO push
- wFIFO_wdata  out  BITS_PER_ROW+MAT_S_W+ROW_S_W+1  {1'b0, mat, row, data}
- wFIFO_full  in  1  bank write FIFO full
- rFIFO_WEN  out  1  bank read-request push
- rFIFO_wdata  out  WORD_W+MAT_S_W+ROW_S_W+2  {type[1:0], mat, row, addr}
- rFIFO_full  in  1  bank read FIFO full
- dramFIFO_REN  out  1  pop DRAM response
- dramFIFO_empty  in  1  DRAM response FIFO empty
- dramFIFO_rdata  in  WORD_W+BITS_PER_ROW+MAT_S_W+ROW_S_W  head entry (first-word-fall-through)
- gemmFIFO_REN  out  1  pop GEMM response
- gemmFIFO_empty  in  1  GEMM response FIFO empty
- gemmFIFO_rdata  in  BITS_PER_ROW+MAT_S_W+ROW_S_W+2  head entry (first-word-fall-through)
- gemm_complete  in  1  bank GEMM-done flag, passed to gemm_done
- st_valid / st_pkt  out  1 / dramFIFO_rdata width  registered DRAM response
- st_ready  in  1  DRAM side accepts st_pkt
- gm_valid / gm_pkt  out  1 / gemmFIFO_rdata width  registered GEMM response
- gm_ready  in  1  GEMM side accepts gm_pkt
- gemm_done  out  1  registered copy of gemm_complete

Behaviour:
- Reset (nRST low at posedge): state IDLE, row counter 0. All outputs 0 except cmd_ready=1; st/gm registers invalid. Mid-operation reset abandons the command with no done pulse.
- FSM states: IDLE, LOAD, RDREQ, DONE.
- IDLE: cmd_valid && cmd_ready latches op, mat, addr and sets row=0. Next state: LOAD for op 00; RDREQ for 01/10; DONE for 11.
- LOAD:
  - ld_ready = !wFIFO_full; wFIFO_WEN = ld_valid && !wFIFO_full (same cycle, combinational).
  - wdata = {0, mat, row, ld_data}.
  - Each push increments row; the push at row==ROWS-1 goes to DONE.
- RDREQ:
  - rFIFO_WEN = !rFIFO_full.
  - type = 00 for STORE, 01 for FETCH.
  - addr = base + row*(BITS_PER_ROW/8), truncated to WORD_W (wraps modulo 2^WORD_W).
  - Last row goes to DONE.
  - full holds the FSM; no push that cycle.
- DONE: done=1 for one cycle, then IDLE. cmd_ready=0 in every non-IDLE state.
- Latency: ROWS-row command with no backpressure gives done at cycle ROWS+2 after the accept edge.
- Response drain (independent of FSM, runs in every state):
  - dramFIFO_REN = !dramFIFO_empty && (!st_valid || st_ready).
  - On pop, st_pkt <= dramFIFO_rdata and st_valid <= 1.
  - st_valid clears on st_ready with no pop.
  - Pop and consume in the same cycle gives full throughput.
  - GEMM path is identical (gm_*).
- gemm_done <= gemm_complete, one-cycle delay.
- Never assert REN while the matching empty is high; never assert WEN while the matching full is high.

Decomposition:
- types_pkg gains: sp_op_t enum (LOAD/STORE/FETCH/NOP), rreq_type_t (DRAM=00, GEMM=01), and packed structs wfifo_pkt_t and rfifo_pkt_t matching the wdata layouts.
- Sub-module sp_resp_slot: one-entry valid/ready register, instantiated twice (DRAM, GEMM).

Test Plan:
- LOAD mat=5, 4 beats 0xA..0xD, no stalls -> four wFIFO_WEN cycles, wdata rows 0..3 with mat=5; done at cycle 6 after accept.
- STORE addr=0x1000 mat=2 -> rFIFO addrs 0x1000, 0x1008, 0x1010, 0x1018, type 00; FETCH -> same addresses, type 01.
- rFIFO_full high for 3 cycles after row 1 -> no WEN during those cycles, rows 2..3 resume, done delayed by 3.
- STORE addr=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0x0, 0x8, 0x10.
- dramFIFO holds 3 entries, st_ready low 2 cycles then high -> st_pkt order preserved, REN never pops while st_valid && !st_ready.
- nRST low during LOAD row 2 -> next cycle IDLE, cmd_ready=1, no done; a new command is accepted normally.
